proc_control: RTL and testbench
===============================

# proc_control

Control unit for the multicycle datapath. It drives the load enables that the datapath registers (R0–R7, A, G, IR) sample on the rising clock edge. It also drives the bus-source selects and the adder/subtractor mode. The block decodes the 9-bit instruction word held in IR, formatted III XXX YYY (opcode, destination Rx, source Ry), and steps through time slots T0–T3, asserting one register-load set per cycle.

## Interface
Parameters:
- none; opcode and slot encodings come from the shared package.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  start request; sampled only in T0.
- IR  in  9  current instruction word: IR[8:6] opcode, IR[5:3] X, IR[2:0] Y.
- IRin  out  1  instruction-register load enable.
- Rin  out  8  one-hot load enables for R0–R7.
- Rout  out  8  one-hot bus-drive selects for R0–R7.
- Ain  out  1  A register load enable.
- Gin  out  1  G register load enable.
- Gout  out  1  G drives the bus.
- DINout  out  1  DIN drives the bus.
- AddSub  out  1  0 = A+bus, 1 = A−bus.
- Done  out  1  final cycle of the current instruction.

## Operation
- State: a 2-bit time-slot counter Tstep with values T0, T1, T2, T3.
- Outputs are combinational from Tstep and IR; at most one load set and at most one bus source are active per cycle.
- Outputs not asserted by a slot are 0. The bus-source signals (Rout, Gout, DINout) are mutually exclusive in every cycle.
- Opcodes:
  - 000 mv: Rx ← Ry.
  - 001 mvi: Rx ← DIN.
  - 010 add: Rx ← Rx + Ry.
  - 011 sub: Rx ← Rx − Ry.
  - 100–111 reserved: executed as NOP.
- T0: IRin = Run. If Run = 1, next slot is T1; otherwise stay in T0.
- T1:
  - mv: Rout[Y], Rin[X], Done.
  - mvi: DINout, Rin[X], Done.
  - add/sub: Rout[X], Ain.
  - reserved: Done only, no loads.
- T2 (add/sub): Rout[Y], Gin; AddSub = 0 for add, 1 for sub.
- T3 (add/sub): Gout, Rin[X], Done.
- Done = 1 forces the next slot to T0. Otherwise the slot advances T1→T2→T3.
- Run is ignored outside T0. Run held high issues instructions back-to-back, one IR load per instruction.
- X = Y is legal:
  - mv R3,R3 asserts Rout[3] and Rin[3] together.
  - add R3,R3 doubles R3.
- IR changes in T1–T3 are illegal. The datapath loads IR only via IRin, so IR is stable during an instruction.

## Timing
- Reset: Resetn low forces Tstep = T0 immediately, without waiting for a clock edge. While Resetn is low, every output is 0 except IRin, which follows Run.
- Reset in the middle of an instruction abandons it; no further Rin/Gin/Ain pulses are issued.
- Latency from the T0 cycle with Run = 1:
  - mv, mvi, reserved: 2 cycles, Done in T1.
  - add, sub: 4 cycles, Done in T3.
- Target registers load on the rising edge that ends the cycle in which their enable is high. For mv/mvi, Rx holds its new value one cycle after Done.
- Done is high for exactly one cycle per instruction.

## Structure
- Shared package `proc_pkg`:
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB;
  - slot encodings T0–T3;
  - IR field positions.
- Sub-module `dec3to8`: 3-to-8 one-hot decoder with an enable input. Instantiated twice, for X and Y, to produce the Rin and Rout vectors.
- Tstep register: one clocked always block with async reset. Next-slot and output logic: one combinational block.

## Test plan
- Reset and Run handling: Resetn low, then Run = 0 for 5 cycles → Tstep stays T0, all outputs 0 except IRin = Run; no Done.
- mvi: IR = 001_010_000, Run = 1 → T1 asserts DINout and Rin = 8'b00000100 with Done; next cycle is T0.
- mv: IR = 000_001_110 → T1 asserts Rout = 8'b01000000 and Rin = 8'b00000010 with Done, all in a single cycle.
- add: IR = 010_000_001 →
  - T1: Rout[0] and Ain.
  - T2: Rout[1], Gin, AddSub = 0.
  - T3: Gout, Rin[0], Done.
  - Done at cycle 4.
- sub with Run held high: 011_011_011 followed by mvi → T2 shows AddSub = 1. IRin is high in the T0 immediately after T3, and the mvi completes 2 cycles later.
- Reset mid-instruction: drop Resetn during T2 of an add → Tstep = T0 without a clock edge; no Gout or Rin pulse follows. A reserved opcode 111 → Done in T1 with Rin = 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared encodings for the multicycle processor control path:
// opcodes, time-slot values and instruction-word field positions.
package proc_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Instruction word layout: III XXX YYY
    localparam int IR_OP_HI = 8;
    localparam int IR_OP_LO = 6;
    localparam int IR_X_HI  = 5;
    localparam int IR_X_LO  = 3;
    localparam int IR_Y_HI  = 2;
    localparam int IR_Y_LO  = 0;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] w,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) y[w] = 1'b1;
    end

endmodule

// File: rtl/proc_control.sv
// Control unit for the multicycle datapath: steps T0..T3 and drives
// register load enables, bus-source selects and the add/sub mode from IR.
module proc_control
    import proc_pkg::*;
(
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] IR,
    output logic       IRin,
    output logic [7:0] Rin,
    output logic [7:0] Rout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       DINout,
    output logic       AddSub,
    output logic       Done
);

    tstep_e     tstep_q, tstep_d;
    logic [2:0] op, rx, ry, rout_sel;
    logic       rin_en, rout_en, is_arith;

    assign op       = IR[IR_OP_HI:IR_OP_LO];
    assign rx       = IR[IR_X_HI:IR_X_LO];
    assign ry       = IR[IR_Y_HI:IR_Y_LO];
    assign is_arith = (op == OP_ADD) || (op == OP_SUB);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) tstep_q <= T0;
        else         tstep_q <= tstep_d;
    end

    always_comb begin
        tstep_d  = T0;
        IRin     = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        Gout     = 1'b0;
        DINout   = 1'b0;
        AddSub   = 1'b0;
        Done     = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_sel = ry;
        case (tstep_q)
            T0: begin
                IRin    = Run;
                tstep_d = Run ? T1 : T0;
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        rout_en = 1'b1;
                        rin_en  = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        rin_en = 1'b1;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_en  = 1'b1;
                        rout_sel = rx;
                        Ain      = 1'b1;
                        tstep_d  = T2;
                    end
                    default: Done = 1'b1;  // reserved opcodes retire as NOP
                endcase
            end
            T2: begin
                // Only arithmetic reaches T2; anything else falls back to T0 quietly.
                if (is_arith) begin
                    rout_en = 1'b1;
                    Gin     = 1'b1;
                    AddSub  = (op == OP_SUB);
                    tstep_d = T3;
                end
            end
            T3: begin
                Gout   = 1'b1;
                rin_en = 1'b1;
                Done   = 1'b1;
            end
            default: tstep_d = T0;
        endcase
    end

    dec3to8 u_dec_x (.en(rin_en),  .w(rx),       .y(Rin));
    dec3to8 u_dec_y (.en(rout_en), .w(rout_sel), .y(Rout));

endmodule

// File: tb/tb_proc_control.sv
// Directed vector table plus randomized instruction stream checked
// against a per-instruction micro-step list model.
module tb_proc_control;

    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic       addsub;
        logic       done;
    } outs_t;

    typedef struct {
        logic       rstn;
        logic       run;
        logic [8:0] ir;
        outs_t      exp;
    } vec_t;

    logic       Clock, Resetn, Run;
    logic [8:0] IR;
    logic       IRin, Ain, Gin, Gout, DINout, AddSub, Done;
    logic [7:0] Rin, Rout;
    outs_t      got;

    int n_checks = 0;
    int n_fail   = 0;

    proc_control dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR),
        .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin),
        .Gout(Gout), .DINout(DINout), .AddSub(AddSub), .Done(Done)
    );

    assign got = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic outs_t mk(logic irin, logic [7:0] rin, logic [7:0] rout,
                                 logic ain, logic gin, logic gout, logic din,
                                 logic addsub, logic done);
        outs_t o;
        o.irin = irin; o.rin = rin; o.rout = rout; o.ain = ain; o.gin = gin;
        o.gout = gout; o.dinout = din; o.addsub = addsub; o.done = done;
        return o;
    endfunction

    task automatic check(input string name, input int idx, input outs_t e);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s[%0d] got=%h expected=%h (irin rin rout ain gin gout din addsub done)",
                     name, idx, got, e);
        end
    endtask

    // Reference model: the list of per-cycle outputs an instruction produces after its T0.
    outs_t mq[$];

    task automatic push_instr(input logic [8:0] ir);
        logic [2:0] op;
        logic [7:0] ox, oy;
        op = ir[8:6];
        ox = 8'd1 << ir[5:3];
        oy = 8'd1 << ir[2:0];
        case (op)
            3'd0: mq.push_back(mk(0, ox, oy, 0, 0, 0, 0, 0, 1));
            3'd1: mq.push_back(mk(0, ox, 8'd0, 0, 0, 0, 1, 0, 1));
            3'd2, 3'd3: begin
                mq.push_back(mk(0, 8'd0, ox, 1, 0, 0, 0, 0, 0));
                mq.push_back(mk(0, 8'd0, oy, 0, 1, 0, 0, op[0], 0));
                mq.push_back(mk(0, ox, 8'd0, 0, 0, 1, 0, 0, 1));
            end
            default: mq.push_back(mk(0, 8'd0, 8'd0, 0, 0, 0, 0, 0, 1));
        endcase
    endtask

    vec_t vecs[$];

    task automatic v(input logic rstn, input logic run, input logic [8:0] ir, input outs_t e);
        vec_t t;
        t.rstn = rstn; t.run = run; t.ir = ir; t.exp = e;
        vecs.push_back(t);
    endtask

    initial begin
        outs_t z, e;
        z = '0;
        Resetn = 1'b0; Run = 1'b0; IR = '0;

        // Reset and idle
        v(0, 0, 9'o000, z);
        v(0, 1, 9'o000, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 9'o000, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) v(1, 0, 9'o000, z);
        // mvi R2
        v(1, 1, 9'b001_010_000, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        v(1, 0, 9'b001_010_000, mk(0, 8'b00000100, 0, 0, 0, 0, 1, 0, 1));
        v(1, 0, 9'b001_010_000, z);
        // mv R1,R6
        v(1, 1, 9'b000_001_110, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        v(1, 0, 9'b000_001_110, mk(0, 8'b00000010, 8'b01000000, 0, 0, 0, 0, 0, 1));
        v(1, 0, 9'b000_001_110, z);
        // add R0,R1
        v(1, 1, 9'b010_000_001, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        v(1, 0, 9'b010_000_001, mk(0, 0, 8'b00000001, 1, 0, 0, 0, 0, 0));
        v(1, 0, 9'b010_000_001, mk(0, 0, 8'b00000010, 0, 1, 0, 0, 0, 0));
        v(1, 0, 9'b010_000_001, mk(0, 8'b00000001, 0, 0, 0, 1, 0, 0, 1));
        v(1, 0, 9'b010_000_001, z);
        // sub R3,R3 with Run held, then mvi R5 back-to-back
        v(1, 1, 9'b011_011_011, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        v(1, 1, 9'b011_011_011, mk(0, 0, 8'b00001000, 1, 0, 0, 0, 0, 0));
        v(1, 1, 9'b011_011_011, mk(0, 0, 8'b00001000, 0, 1, 0, 0, 1, 0));
        v(1, 1, 9'b011_011_011, mk(0, 8'b00001000, 0, 0, 0, 1, 0, 0, 1));
        v(1, 1, 9'b001_101_000, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        v(1, 0, 9'b001_101_000, mk(0, 8'b00100000, 0, 0, 0, 0, 1, 0, 1));
        v(1, 0, 9'b001_101_000, z);
        // reserved opcode 111
        v(1, 1, 9'b111_010_011, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        v(1, 0, 9'b111_010_011, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        v(1, 0, 9'b111_010_011, z);
        // mv R3,R3 and add R3,R3
        v(1, 1, 9'b000_011_011, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        v(1, 0, 9'b000_011_011, mk(0, 8'b00001000, 8'b00001000, 0, 0, 0, 0, 0, 1));
        v(1, 1, 9'b010_011_011, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        v(1, 0, 9'b010_011_011, mk(0, 0, 8'b00001000, 1, 0, 0, 0, 0, 0));
        v(1, 0, 9'b010_011_011, mk(0, 0, 8'b00001000, 0, 1, 0, 0, 0, 0));
        v(1, 0, 9'b010_011_011, mk(0, 8'b00001000, 0, 0, 0, 1, 0, 0, 1));
        v(1, 0, 9'b010_011_011, z);

        foreach (vecs[i]) begin
            @(negedge Clock);
            Resetn = vecs[i].rstn; Run = vecs[i].run; IR = vecs[i].ir;
            #1 check("vec", i, vecs[i].exp);
        end

        // Reset during T2 of an add: must take effect with no clock edge
        @(negedge Clock);
        Run = 1'b1; IR = 9'b010_000_001;
        @(negedge Clock);
        Run = 1'b0;
        @(negedge Clock);
        #1 check("mid_t2", 0, mk(0, 0, 8'b00000010, 0, 1, 0, 0, 0, 0));
        #1 Resetn = 1'b0;
        #1 check("mid_rst", 0, z);
        Run = 1'b1;
        #1 check("rst_irin", 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        Run = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("post_rst", i, z);
            @(negedge Clock);
        end

        // Randomized stream against the micro-step model
        mq.delete();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                Resetn = 1'b0;
                Run    = 1'($urandom_range(0, 1));
                mq.delete();
                e = z; e.irin = Run;
            end else begin
                Resetn = 1'b1;
                if (mq.size() == 0) begin
                    Run = ($urandom_range(0, 3) != 0);
                    IR  = 9'($urandom);
                    e = z; e.irin = Run;
                    if (Run) push_instr(IR);
                end else begin
                    Run = 1'($urandom_range(0, 1));
                    e = mq.pop_front();
                end
            end
            #1 check("rand", c, e);
            @(negedge Clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
